// File: rtl/rq_tag_tracker_if.sv
// Bus bundle between the requester channels, the request builder, the
// completion router and rq_tag_tracker. The tracker takes the slave view and
// the surrounding logic takes the master view.
interface rq_tag_tracker_if #(
  parameter int NUM_CH = 4,
  parameter int TAG_W  = 5
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] req_valid;
  logic [NUM_CH-1:0] req_ready;
  logic [3:0]        pcie_tfc_nph_av;
  logic              alloc_valid;
  logic [TAG_W-1:0]  alloc_tag;
  logic [CH_W-1:0]   alloc_ch;
  logic              alloc_ready;
  logic              cpl_valid;
  logic [TAG_W-1:0]  cpl_tag;
  logic              cpl_last;
  logic              cpl_route_valid;
  logic [CH_W-1:0]   cpl_route_ch;
  logic              cpl_err;
  logic              to_valid;
  logic [TAG_W-1:0]  to_tag;
  logic [CH_W-1:0]   to_ch;
  logic [TAG_W:0]    busy_cnt;
  logic              all_busy;

  modport slave (
    input  req_valid, pcie_tfc_nph_av, alloc_ready, cpl_valid, cpl_tag, cpl_last,
    output req_ready, alloc_valid, alloc_tag, alloc_ch, cpl_route_valid, cpl_route_ch,
           cpl_err, to_valid, to_tag, to_ch, busy_cnt, all_busy
  );

  modport master (
    output req_valid, pcie_tfc_nph_av, alloc_ready, cpl_valid, cpl_tag, cpl_last,
    input  req_ready, alloc_valid, alloc_tag, alloc_ch, cpl_route_valid, cpl_route_ch,
           cpl_err, to_valid, to_tag, to_ch, busy_cnt, all_busy
  );
endinterface

// File: rtl/rq_tag_tracker.sv
// PCIe requester tag allocator and outstanding-request tracker.
// Round-robin grants tags (lowest free first) to NUM_CH channels when NPH
// credits exist, routes completions back to the owning channel and retires
// tags whose completion never arrives, scanning one tag per cycle.
module rq_tag_tracker #(
  parameter int NUM_CH      = 4,
  parameter int TAG_W       = 5,
  parameter int TS_W        = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                clk,
  input  logic                srst,
  rq_tag_tracker_if.slave     bus
);
  localparam int CH_W     = $clog2(NUM_CH);
  localparam int NUM_TAGS = 1 << TAG_W;
  localparam int CNT_W    = TAG_W + 1;

  // Per-tag state
  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [CH_W-1:0]     owner_q [NUM_TAGS];
  logic [TS_W-1:0]     stamp_q [NUM_TAGS];

  // Control state
  logic [TS_W-1:0]     now_q;
  logic [TAG_W-1:0]    scan_idx_q;
  logic [CH_W-1:0]     rr_q;
  logic [CNT_W-1:0]    busy_cnt_q, busy_cnt_d;

  // Registered outputs
  logic                alloc_valid_q;
  logic [TAG_W-1:0]    alloc_tag_q;
  logic [CH_W-1:0]     alloc_ch_q;
  logic                cpl_route_valid_q;
  logic [CH_W-1:0]     cpl_route_ch_q;
  logic                cpl_err_q;
  logic                to_valid_q;
  logic [TAG_W-1:0]    to_tag_q;
  logic [CH_W-1:0]     to_ch_q;

  // Combinational decisions
  logic                free_found;
  logic [TAG_W-1:0]    free_idx;
  logic [NUM_CH-1:0]   req_rot;
  logic [CH_W-1:0]     rr_off;
  logic [CH_W:0]       gnt_sum;
  logic [CH_W-1:0]     gnt_ch;
  logic [CH_W-1:0]     rr_next;
  logic                gnt;
  logic                cpl_hit;
  logic                cpl_free;
  logic [TS_W-1:0]     age;
  logic                to_fire;

  // Lowest-index free tag, taken from the busy vector before this edge so a
  // tag freed now only becomes allocatable next cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = TAG_W'(i);
      end
    end
  end

  // Round-robin pick: rotate requests so rr_q sits at bit 0, take the first set bit.
  always_comb begin
    req_rot = NUM_CH'({bus.req_valid, bus.req_valid} >> rr_q);
    rr_off  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_rot[k]) rr_off = CH_W'(k);
    end
    gnt_sum = {1'b0, rr_q} + {1'b0, rr_off};
    gnt_ch  = (gnt_sum >= (CH_W+1)'(NUM_CH)) ? CH_W'(gnt_sum - (CH_W+1)'(NUM_CH))
                                             : CH_W'(gnt_sum);
    rr_next = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
  end

  assign gnt = !srst && (!alloc_valid_q || bus.alloc_ready) && (|bus.req_valid)
               && free_found && (|bus.pcie_tfc_nph_av);

  // Completion lookup and timeout check; a completion that frees the scanned
  // tag in the same cycle wins over the timeout.
  assign cpl_hit  = bus.cpl_valid && busy_q[bus.cpl_tag];
  assign cpl_free = cpl_hit && bus.cpl_last;
  assign age      = now_q - stamp_q[scan_idx_q];
  assign to_fire  = busy_q[scan_idx_q] && (age >= TS_W'(TIMEOUT_CYC))
                    && !(cpl_free && (bus.cpl_tag == scan_idx_q));

  // Next busy vector and count; grant, completion and timeout never hit the same tag.
  always_comb begin
    busy_d = busy_q;
    if (cpl_free) busy_d[bus.cpl_tag] = 1'b0;
    if (to_fire)  busy_d[scan_idx_q]  = 1'b0;
    if (gnt)      busy_d[free_idx]    = 1'b1;
    busy_cnt_d = busy_cnt_q + CNT_W'(gnt) - CNT_W'(cpl_free) - CNT_W'(to_fire);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (srst) begin
      busy_q            <= '0;
      busy_cnt_q        <= '0;
      now_q             <= '0;
      scan_idx_q        <= '0;
      rr_q              <= '0;
      alloc_valid_q     <= 1'b0;
      alloc_tag_q       <= '0;
      alloc_ch_q        <= '0;
      cpl_route_valid_q <= 1'b0;
      cpl_route_ch_q    <= '0;
      cpl_err_q         <= 1'b0;
      to_valid_q        <= 1'b0;
      to_tag_q          <= '0;
      to_ch_q           <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      now_q      <= now_q + 1'b1;
      scan_idx_q <= scan_idx_q + 1'b1;
      if (gnt) begin
        alloc_valid_q <= 1'b1;
        alloc_tag_q   <= free_idx;
        alloc_ch_q    <= gnt_ch;
        rr_q          <= rr_next;
      end else if (bus.alloc_ready) begin
        alloc_valid_q <= 1'b0;
      end
      cpl_route_valid_q <= cpl_hit;
      cpl_err_q         <= bus.cpl_valid && !busy_q[bus.cpl_tag];
      if (cpl_hit) cpl_route_ch_q <= owner_q[bus.cpl_tag];
      to_valid_q <= to_fire;
      if (to_fire) begin
        to_tag_q <= scan_idx_q;
        to_ch_q  <= owner_q[scan_idx_q];
      end
    end
  end

  // Owner and start stamp of each tag, written on grant.
  always_ff @(posedge clk) begin
    // NOTE: these arrays are not reset; their contents are only read while the tag's busy bit is set.
    if (gnt) begin
      owner_q[free_idx] <= gnt_ch;
      stamp_q[free_idx] <= now_q;
    end
  end

  assign bus.req_ready       = gnt ? (NUM_CH'(1) << gnt_ch) : '0;
  assign bus.alloc_valid     = alloc_valid_q;
  assign bus.alloc_tag       = alloc_tag_q;
  assign bus.alloc_ch        = alloc_ch_q;
  assign bus.cpl_route_valid = cpl_route_valid_q;
  assign bus.cpl_route_ch    = cpl_route_ch_q;
  assign bus.cpl_err         = cpl_err_q;
  assign bus.to_valid        = to_valid_q;
  assign bus.to_tag          = to_tag_q;
  assign bus.to_ch           = to_ch_q;
  assign bus.busy_cnt        = busy_cnt_q;
  assign bus.all_busy        = (busy_cnt_q == CNT_W'(NUM_TAGS));

  a_cnt_matches_busy: assert property (@(posedge clk) disable iff (srst)
    busy_cnt_q == CNT_W'($countones(busy_q)));
  a_cnt_in_range: assert property (@(posedge clk)
    busy_cnt_q <= CNT_W'(NUM_TAGS));
endmodule

// File: tb/tb_rq_tag_tracker.sv
// Directed bench for rq_tag_tracker: reset, round-robin back-to-back grants,
// pool exhaustion and tag reuse, credit/handshake stalls, completion timeout
// and mid-stream reset.
module tb_rq_tag_tracker;
  localparam int NUM_CH = 4;
  localparam int TAG_W  = 5;

  logic clk = 1'b0;
  logic srst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rq_tag_tracker_if #(.NUM_CH(NUM_CH), .TAG_W(TAG_W)) bus ();

  rq_tag_tracker #(
    .NUM_CH(NUM_CH), .TAG_W(TAG_W), .TS_W(16), .TIMEOUT_CYC(100)
  ) dut (
    .clk (clk),
    .srst(srst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid       = '0;
    bus.pcie_tfc_nph_av = 4'd4;
    bus.alloc_ready     = 1'b1;
    bus.cpl_valid       = 1'b0;
    bus.cpl_tag         = '0;
    bus.cpl_last        = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    srst = 1'b1;
    tick();
    tick();
    srst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.alloc_valid, bus.cpl_route_valid, bus.cpl_err, bus.to_valid, bus.all_busy} !== 5'b0
        || bus.busy_cnt !== 6'd0 || bus.alloc_tag !== 5'd0 || bus.alloc_ch !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs got av=%b cnt=%0d tag=%0d ch=%0d exp all zero",
               bus.alloc_valid, bus.busy_cnt, bus.alloc_tag, bus.alloc_ch);
    end
  endtask

  task automatic test_single_grant();
    do_reset();
    bus.req_valid = 4'b0001;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL t1_req_ready got %b exp 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    checks++;
    if (bus.alloc_valid !== 1'b1 || bus.alloc_tag !== 5'd0 || bus.alloc_ch !== 2'd0 || bus.busy_cnt !== 6'd1) begin
      errors++;
      $display("FAIL t1_alloc got v=%b tag=%0d ch=%0d cnt=%0d exp v=1 tag=0 ch=0 cnt=1",
               bus.alloc_valid, bus.alloc_tag, bus.alloc_ch, bus.busy_cnt);
    end
    tick();
    checks++;
    if (bus.alloc_valid !== 1'b0) begin
      errors++; $display("FAIL t1_alloc_drop got %b exp 0", bus.alloc_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_rdy;
    do_reset();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_rdy = 4'b0001 << (i % 4);
      #1;
      checks++;
      if (bus.req_ready !== exp_rdy) begin
        errors++; $display("FAIL t2_req_ready[%0d] got %b exp %b", i, bus.req_ready, exp_rdy);
      end
      tick();
      checks++;
      if (bus.alloc_valid !== 1'b1 || bus.alloc_tag !== 5'(i) || bus.alloc_ch !== 2'(i % 4)) begin
        errors++;
        $display("FAIL t2_alloc[%0d] got v=%b tag=%0d ch=%0d exp v=1 tag=%0d ch=%0d",
                 i, bus.alloc_valid, bus.alloc_tag, bus.alloc_ch, i, i % 4);
      end
    end
    bus.req_valid = '0;
    checks++;
    if (bus.busy_cnt !== 6'd5) begin
      errors++; $display("FAIL t2_busy_cnt got %0d exp 5", bus.busy_cnt);
    end
  endtask

  task automatic test_pool_full();
    do_reset();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 32; i++) begin
      tick();
      checks++;
      if (bus.alloc_tag !== 5'(i) || bus.alloc_ch !== 2'(i % 4)) begin
        errors++;
        $display("FAIL t3_fill[%0d] got tag=%0d ch=%0d exp tag=%0d ch=%0d",
                 i, bus.alloc_tag, bus.alloc_ch, i, i % 4);
      end
    end
    #1;
    checks++;
    if (bus.all_busy !== 1'b1 || bus.busy_cnt !== 6'd32 || bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL t3_full got all_busy=%b cnt=%0d rdy=%b exp 1 32 0000",
               bus.all_busy, bus.busy_cnt, bus.req_ready);
    end
    // Free tag 7 (owned by channel 3); it must not be re-granted in the same cycle.
    bus.cpl_valid = 1'b1; bus.cpl_tag = 5'd7; bus.cpl_last = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL t3_same_cycle_realloc got %b exp 0000", bus.req_ready);
    end
    tick();
    bus.cpl_valid = 1'b0; bus.cpl_last = 1'b0;
    checks++;
    if (bus.cpl_route_valid !== 1'b1 || bus.cpl_route_ch !== 2'd3 || bus.cpl_err !== 1'b0
        || bus.busy_cnt !== 6'd31 || bus.all_busy !== 1'b0) begin
      errors++;
      $display("FAIL t3_route got v=%b ch=%0d err=%b cnt=%0d all=%b exp 1 3 0 31 0",
               bus.cpl_route_valid, bus.cpl_route_ch, bus.cpl_err, bus.busy_cnt, bus.all_busy);
    end
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL t3_regrant_rdy got %b exp 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    checks++;
    if (bus.alloc_valid !== 1'b1 || bus.alloc_tag !== 5'd7 || bus.alloc_ch !== 2'd0 || bus.cpl_route_valid !== 1'b0) begin
      errors++;
      $display("FAIL t3_regrant got v=%b tag=%0d ch=%0d route=%b exp 1 7 0 0",
               bus.alloc_valid, bus.alloc_tag, bus.alloc_ch, bus.cpl_route_valid);
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.pcie_tfc_nph_av = 4'd0;
    bus.req_valid = 4'b0010;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL t4_no_credit_rdy got %b exp 0000", bus.req_ready);
    end
    tick();
    checks++;
    if (bus.alloc_valid !== 1'b0 || bus.busy_cnt !== 6'd0) begin
      errors++; $display("FAIL t4_no_credit got v=%b cnt=%0d exp 0 0", bus.alloc_valid, bus.busy_cnt);
    end
    bus.pcie_tfc_nph_av = 4'd4;
    bus.alloc_ready = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++; $display("FAIL t4_grant_rdy got %b exp 0010", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (bus.req_ready !== 4'b0000 || bus.alloc_valid !== 1'b1 || bus.alloc_tag !== 5'd0
          || bus.alloc_ch !== 2'd1 || bus.busy_cnt !== 6'd1) begin
        errors++;
        $display("FAIL t4_hold[%0d] got rdy=%b v=%b tag=%0d ch=%0d cnt=%0d exp 0000 1 0 1 1",
                 i, bus.req_ready, bus.alloc_valid, bus.alloc_tag, bus.alloc_ch, bus.busy_cnt);
      end
      tick();
    end
    bus.alloc_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++; $display("FAIL t4_release_rdy got %b exp 0100", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    checks++;
    if (bus.alloc_valid !== 1'b1 || bus.alloc_tag !== 5'd1 || bus.alloc_ch !== 2'd2) begin
      errors++;
      $display("FAIL t4_release got v=%b tag=%0d ch=%0d exp 1 1 2", bus.alloc_valid, bus.alloc_tag, bus.alloc_ch);
    end
  endtask

  task automatic test_timeout();
    int  seen_at;
    bit  seen;
    do_reset();
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
    seen = 1'b0;
    seen_at = 0;
    for (int c = 1; c <= 300 && !seen; c++) begin
      tick();
      if (bus.to_valid === 1'b1) begin
        seen = 1'b1;
        seen_at = c;
      end
    end
    checks++;
    if (!seen || seen_at < 100 || seen_at > 132) begin
      errors++; $display("FAIL t5_timeout_window got seen=%b at=%0d exp 100..132", seen, seen_at);
    end
    checks++;
    if (bus.to_tag !== 5'd0 || bus.to_ch !== 2'd0 || bus.busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL t5_timeout_info got tag=%0d ch=%0d cnt=%0d exp 0 0 0", bus.to_tag, bus.to_ch, bus.busy_cnt);
    end
    tick();
    checks++;
    if (bus.to_valid !== 1'b0) begin
      errors++; $display("FAIL t5_to_pulse got %b exp 0", bus.to_valid);
    end
    bus.cpl_valid = 1'b1; bus.cpl_tag = 5'd0; bus.cpl_last = 1'b1;
    tick();
    bus.cpl_valid = 1'b0; bus.cpl_last = 1'b0;
    checks++;
    if (bus.cpl_err !== 1'b1 || bus.cpl_route_valid !== 1'b0 || bus.busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL t5_late_cpl got err=%b route=%b cnt=%0d exp 1 0 0", bus.cpl_err, bus.cpl_route_valid, bus.busy_cnt);
    end
    tick();
    checks++;
    if (bus.cpl_err !== 1'b0) begin
      errors++; $display("FAIL t5_err_pulse got %b exp 0", bus.cpl_err);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (bus.busy_cnt !== 6'd8) begin
      errors++; $display("FAIL t6_busy8 got %0d exp 8", bus.busy_cnt);
    end
    srst = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL t6_rdy_in_reset got %b exp 0000", bus.req_ready);
    end
    tick();
    srst = 1'b0;
    bus.req_valid = '0;
    checks++;
    if (bus.busy_cnt !== 6'd0 || bus.alloc_valid !== 1'b0) begin
      errors++; $display("FAIL t6_after_reset got cnt=%0d v=%b exp 0 0", bus.busy_cnt, bus.alloc_valid);
    end
    bus.cpl_valid = 1'b1; bus.cpl_tag = 5'd3; bus.cpl_last = 1'b1;
    tick();
    bus.cpl_valid = 1'b0; bus.cpl_last = 1'b0;
    checks++;
    if (bus.cpl_err !== 1'b1 || bus.cpl_route_valid !== 1'b0) begin
      errors++; $display("FAIL t6_stale_cpl got err=%b route=%b exp 1 0", bus.cpl_err, bus.cpl_route_valid);
    end
    bus.req_valid = 4'b0100;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++; $display("FAIL t6_new_rdy got %b exp 0100", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    checks++;
    if (bus.alloc_valid !== 1'b1 || bus.alloc_tag !== 5'd0 || bus.alloc_ch !== 2'd2 || bus.busy_cnt !== 6'd1) begin
      errors++;
      $display("FAIL t6_new_alloc got v=%b tag=%0d ch=%0d cnt=%0d exp 1 0 2 1",
               bus.alloc_valid, bus.alloc_tag, bus.alloc_ch, bus.busy_cnt);
    end
  endtask

  initial begin
    srst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_grant();
    test_back_to_back();
    test_pool_full();
    test_stall();
    test_timeout();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
